// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/redirect controller.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_RUN      = 2'd0,
        PC_REDIRECT = 2'd1,
        PC_DRAIN    = 2'd2,
        PC_HALTED   = 2'd3
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic id;
        logic ex;
        logic mem;
        logic wb;
    } stage_valid_t;

    localparam int REDIRECT_CNT_W = 3;

    function automatic logic any_valid(input stage_valid_t v);
        return v.id | v.ex | v.mem | v.wb;
    endfunction

endpackage

// File: rtl/pipe_perf_counter.sv
// Free-running event counter, wraps modulo 2^PERF_W, cleared by synchronous reset.
module pipe_perf_counter #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    logic [PERF_W-1:0] r_count;

    // count one event per cycle that inc is high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + PERF_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/redirect controller: turns hazard, memory-stall, branch and
// trap indications into per-stage load enables and stage valid bits, and owns
// the run/redirect/drain/halt sequencing of fetch.
// Optional build macro PIPE_CTRL_PERF_EN adds four performance counters.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// PC_RUN      | normal operation, fetch output accepted
// PC_REDIRECT | fetch output discarded for REDIRECT_BUBBLES cycles
// PC_DRAIN    | fetch stopped, older instructions run to completion
// PC_HALTED   | pipeline empty, everything frozen until halt_req drops
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int PERF_W           = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic if_inst_ready,
    input  logic data_hazard_ID,
    input  logic mem_busy,
    input  logic branch_taken_EX,
    input  logic trap_WB,
    input  logic halt_req,
    output logic id_valid,
    output logic ex_valid,
    output logic mem_valid,
    output logic wb_valid,
    output logic if_en,
    output logic id_en,
    output logic ex_en,
    output logic mem_en,
    output logic pc_redirect,
    output logic halted
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_hazard_stalls,
    output logic [PERF_W-1:0] perf_mem_stalls,
    output logic [PERF_W-1:0] perf_flushes
`endif
);

    localparam logic [REDIRECT_CNT_W-1:0] LP_CNT_LAST = REDIRECT_CNT_W'(REDIRECT_BUBBLES - 1);

    pipe_ctrl_state_t            r_state;
    pipe_ctrl_state_t            w_state_nxt;
    logic [REDIRECT_CNT_W-1:0]   r_cnt;
    logic [REDIRECT_CNT_W-1:0]   w_cnt_nxt;
    stage_valid_t                r_valid;
    stage_valid_t                w_valid_nxt;

    logic w_fetch_ok;
    logic w_trap;
    logic w_mem_stall;
    logic w_br;
    logic w_haz;
    logic w_redirect;
    logic w_if_en;
    logic w_id_en;
    logic w_ex_en;
    logic w_mem_en;

    // Priority-qualified stall causes: each one is masked by every higher cause,
    // so at most one of them is active in a cycle.
    assign w_fetch_ok  = (r_state == PC_RUN);
    assign w_trap      = trap_WB & r_valid.wb;
    assign w_mem_stall = ~w_trap & mem_busy & r_valid.mem;
    assign w_br        = ~w_trap & ~w_mem_stall & branch_taken_EX & r_valid.ex;
    assign w_haz       = ~w_trap & ~w_mem_stall & ~w_br & data_hazard_ID & r_valid.id;
    assign w_redirect  = w_trap | w_br;

    // stage enables and next valid bits from the winning stall cause
    always_comb begin
        w_valid_nxt = r_valid;
        w_if_en     = 1'b0;
        w_id_en     = 1'b0;
        w_ex_en     = 1'b0;
        w_mem_en    = 1'b0;
        if (r_state == PC_HALTED) begin
            w_valid_nxt = r_valid;
        end else if (w_trap) begin
            {w_if_en, w_id_en, w_ex_en, w_mem_en} = 4'b1111;
            w_valid_nxt = '0;
        end else if (w_mem_stall) begin
            // younger stages freeze; WB receives a bubble
            w_valid_nxt.wb = 1'b0;
        end else if (w_br) begin
            {w_if_en, w_id_en, w_ex_en, w_mem_en} = 4'b1111;
            w_valid_nxt.id  = 1'b0;
            w_valid_nxt.ex  = 1'b0;
            w_valid_nxt.mem = 1'b1;
            w_valid_nxt.wb  = r_valid.mem;
        end else if (w_haz) begin
            // ID holds its instruction, EX takes a bubble
            w_ex_en         = 1'b1;
            w_mem_en        = 1'b1;
            w_valid_nxt.ex  = 1'b0;
            w_valid_nxt.mem = r_valid.ex;
            w_valid_nxt.wb  = r_valid.mem;
        end else begin
            {w_if_en, w_id_en, w_ex_en, w_mem_en} = 4'b1111;
            w_valid_nxt.id  = if_inst_ready & w_fetch_ok;
            w_valid_nxt.ex  = r_valid.id;
            w_valid_nxt.mem = r_valid.ex;
            w_valid_nxt.wb  = r_valid.mem;
        end
    end

    // FSM next state and redirect bubble counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            PC_RUN: begin
                if (w_redirect) begin
                    w_state_nxt = PC_REDIRECT;
                    w_cnt_nxt   = '0;
                end else if (halt_req) begin
                    w_state_nxt = PC_DRAIN;
                end
            end
            PC_REDIRECT: begin
                if (w_redirect) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = halt_req ? PC_DRAIN : PC_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + REDIRECT_CNT_W'(1);
                end
            end
            PC_DRAIN: begin
                // a redirect while draining only flushes; fetch stays stopped
                if (!w_redirect && !any_valid(r_valid)) begin
                    w_state_nxt = PC_HALTED;
                end
            end
            PC_HALTED: begin
                if (!halt_req) begin
                    w_state_nxt = PC_REDIRECT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = PC_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // state, bubble counter and stage valid registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PC_RUN;
            r_cnt   <= '0;
            r_valid <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Enables and redirect are held low while reset is asserted.
    assign if_en       = w_if_en  & ~reset;
    assign id_en       = w_id_en  & ~reset;
    assign ex_en       = w_ex_en  & ~reset;
    assign mem_en      = w_mem_en & ~reset;
    assign pc_redirect = w_redirect & ~reset;
    assign halted      = (r_state == PC_HALTED) & ~reset;

    assign id_valid  = r_valid.id;
    assign ex_valid  = r_valid.ex;
    assign mem_valid = r_valid.mem;
    assign wb_valid  = r_valid.wb;

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_counter #(.PERF_W(PERF_W)) u_perf_cycles (
        .clk   (clk),
        .reset (reset),
        .inc   (1'b1),
        .count (perf_cycles)
    );

    pipe_perf_counter #(.PERF_W(PERF_W)) u_perf_hazard (
        .clk   (clk),
        .reset (reset),
        .inc   (w_haz),
        .count (perf_hazard_stalls)
    );

    pipe_perf_counter #(.PERF_W(PERF_W)) u_perf_mem (
        .clk   (clk),
        .reset (reset),
        .inc   (w_mem_stall),
        .count (perf_mem_stalls)
    );

    pipe_perf_counter #(.PERF_W(PERF_W)) u_perf_flush (
        .clk   (clk),
        .reset (reset),
        .inc   (w_redirect),
        .count (perf_flushes)
    );
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with REDIRECT_BUBBLES=2, PERF_W=4.
// Counter checks are compiled in when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic if_inst_ready, data_hazard_ID, mem_busy, branch_taken_EX, trap_WB, halt_req;
    logic id_valid, ex_valid, mem_valid, wb_valid;
    logic if_en, id_en, ex_en, mem_en, pc_redirect, halted;
`ifdef PIPE_CTRL_PERF_EN
    logic [3:0] perf_cycles, perf_hazard_stalls, perf_mem_stalls, perf_flushes;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.REDIRECT_BUBBLES(2), .PERF_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .if_inst_ready   (if_inst_ready),
        .data_hazard_ID  (data_hazard_ID),
        .mem_busy        (mem_busy),
        .branch_taken_EX (branch_taken_EX),
        .trap_WB         (trap_WB),
        .halt_req        (halt_req),
        .id_valid        (id_valid),
        .ex_valid        (ex_valid),
        .mem_valid       (mem_valid),
        .wb_valid        (wb_valid),
        .if_en           (if_en),
        .id_en           (id_en),
        .ex_en           (ex_en),
        .mem_en          (mem_en),
        .pc_redirect     (pc_redirect),
        .halted          (halted)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_cycles        (perf_cycles),
        .perf_hazard_stalls (perf_hazard_stalls),
        .perf_mem_stalls    (perf_mem_stalls),
        .perf_flushes       (perf_flushes)
`endif
    );

    // inputs for one cycle, expected comb outputs in that cycle, expected valids after the edge
    typedef struct {
        logic       ir, hz, mb, br, tr, hl;
        logic [3:0] en;   // {if,id,ex,mem}
        logic       pcr;
        logic       hlt;
        logic [3:0] v;    // {id,ex,mem,wb}
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic ir, hz, mb, br, tr, hl,
                       input logic [3:0] en, input logic pcr, hlt, input logic [3:0] v);
        vec_t t;
        t.ir = ir; t.hz = hz; t.mb = mb; t.br = br; t.tr = tr; t.hl = hl;
        t.en = en; t.pcr = pcr; t.hlt = hlt; t.v = v;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic ir, hz, mb, br, tr, hl);
        if_inst_ready = ir; data_hazard_ID = hz; mem_busy = mb;
        branch_taken_EX = br; trap_WB = tr; halt_req = hl;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        //     ir hz mb br tr hl   en      pcr hlt  v
        // fill after reset
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1000); // 0
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1100);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1110);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1111);
        // two-cycle data hazard
        add(1, 1, 0, 0, 0, 0, 4'b0011, 0, 0, 4'b1011); // 4
        add(1, 1, 0, 0, 0, 0, 4'b0011, 0, 0, 4'b1001);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1100);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1110);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1111);
        // branch held by mem_busy for 3 cycles, then redirect
        add(1, 0, 1, 1, 0, 0, 4'b0000, 0, 0, 4'b1110); // 9
        add(1, 0, 1, 1, 0, 0, 4'b0000, 0, 0, 4'b1110);
        add(1, 0, 1, 1, 0, 0, 4'b0000, 0, 0, 4'b1110);
        add(1, 0, 0, 1, 0, 0, 4'b1111, 1, 0, 4'b0011); // 12
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b0001);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1000);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1100);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1110);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1111);
        // trap + branch + hazard in one cycle
        add(1, 1, 0, 1, 1, 0, 4'b1111, 1, 0, 4'b0000); // 19
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1000);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1100);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1110);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1111);
        // halt with full pipe, then release
        add(1, 0, 0, 0, 0, 1, 4'b1111, 0, 0, 4'b1111); // 26
        add(1, 0, 0, 0, 0, 1, 4'b1111, 0, 0, 4'b0111);
        add(1, 0, 0, 0, 0, 1, 4'b1111, 0, 0, 4'b0011);
        add(1, 0, 0, 0, 0, 1, 4'b1111, 0, 0, 4'b0001);
        add(1, 0, 0, 0, 0, 1, 4'b1111, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 1, 4'b1111, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 1, 4'b0000, 0, 1, 4'b0000); // 32
        add(1, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1000); // 36
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1100);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1110);
        // branch beats hazard; trap in REDIRECT restarts the bubble count
        add(1, 1, 0, 1, 0, 0, 4'b1111, 1, 0, 4'b0011); // 39
        add(1, 0, 0, 0, 1, 0, 4'b1111, 1, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1000);
        // trap / mem_busy on empty stages are ignored
        add(1, 0, 0, 0, 1, 0, 4'b1111, 0, 0, 4'b1100); // 44
        add(1, 0, 1, 0, 0, 0, 4'b1111, 0, 0, 4'b1110);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1111);
        // trap during DRAIN stays in DRAIN
        add(1, 0, 0, 0, 0, 1, 4'b1111, 0, 0, 4'b1111); // 47
        add(1, 0, 0, 0, 1, 1, 4'b1111, 1, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 1, 4'b1111, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 1, 4'b0000, 0, 1, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1000); // 54
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1100);
        add(1, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1110);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valids", {id_valid, ex_valid, mem_valid, wb_valid}, 4'b0000);
        chk("rst_en", {if_en, id_en, ex_en, mem_en}, 4'b0000);
        chk("rst_pcr", pc_redirect, 1'b0);
        chk("rst_halted", halted, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        chk("rst_perf", {perf_cycles, perf_hazard_stalls, perf_mem_stalls, perf_flushes}, 16'h0);
`endif
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ir, tbl[i].hz, tbl[i].mb, tbl[i].br, tbl[i].tr, tbl[i].hl);
            #1;
            chk($sformatf("v%0d_en", i), {if_en, id_en, ex_en, mem_en}, tbl[i].en);
            chk($sformatf("v%0d_pcr", i), pc_redirect, tbl[i].pcr);
            chk($sformatf("v%0d_halted", i), halted, tbl[i].hlt);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valids", i), {id_valid, ex_valid, mem_valid, wb_valid}, tbl[i].v);
            @(negedge clk);
        end

`ifdef PIPE_CTRL_PERF_EN
        // flushes: vectors 12,19,39,40,48; mem stalls 9..11; hazards 4,5
        chk("perf_flushes", perf_flushes, 4'd5);
        chk("perf_mem", perf_mem_stalls, 4'd3);
        chk("perf_hazard", perf_hazard_stalls, 4'd2);
        chk("perf_cycles_tbl", perf_cycles, 32'(tbl.size() % 16));
`endif

        // reset in the middle of a memory stall
        drive(1, 0, 1, 0, 0, 0);
        #1;
        chk("stall_en", {if_en, id_en, ex_en, mem_en}, 4'b0000);
        @(posedge clk);
        #1;
        chk("stall_valids", {id_valid, ex_valid, mem_valid, wb_valid}, 4'b1110);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_en", {if_en, id_en, ex_en, mem_en}, 4'b0000);
        chk("midrst_pcr", pc_redirect, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst_valids", {id_valid, ex_valid, mem_valid, wb_valid}, 4'b0000);
        chk("midrst_halted", halted, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        chk("midrst_perf", {perf_cycles, perf_hazard_stalls, perf_mem_stalls, perf_flushes}, 16'h0);
`endif
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (17) @(posedge clk);
        #1;
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_wrap", perf_cycles, 4'd1);
`endif
        chk("idle_valids", {id_valid, ex_valid, mem_valid, wb_valid}, 4'b0000);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("restart_valids", {id_valid, ex_valid, mem_valid, wb_valid}, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
